keypad_scan_ctrl: RTL and testbench

Row-scan sequencer and shared debounce timer for the 4x4 keypad front end. It drives the keypad rows one-hot and synchronizes the raw column inputs. It presents masked column/row codes to the keypad control FSM, freezes scanning while that FSM owns a key, and services its debounce requests with `dbhigh`/`dblow` pulses. It sits between the keypad pins and the control FSM.

---
 rtl/keypad_pkg.sv | 13 +
 rtl/sync2.sv | 23 ++
 rtl/keypad_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front end.
package keypad_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'b00,
        SCAN  = 2'b01,
        HOLD  = 2'b10
    } scan_state_t;

    localparam int         BLANK_CYCLES = 3;
    localparam logic [3:0] ROW_INIT     = 4'b0001;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad row-scan sequencer with shared debounce timer.
// Optional KEYSCAN_DEBUG_EN adds debug_state and a row one-hot error flag.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 1024,
    parameter int DB_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] col_raw,
    output logic [3:0] row_drive,
    output logic [3:0] col,
    output logic [3:0] row,
    input  logic       dbreq,
    input  logic [3:0] active_col,
    output logic       dbhigh,
    output logic       dblow
`ifdef KEYSCAN_DEBUG_EN
    ,
    output logic [1:0] debug_state
`endif
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES);

    scan_state_t   state;
    scan_state_t   state_n;
    logic [CW-1:0] cnt;
    logic [3:0]    col_s;
    logic          rotate;
    logic          cnt_inc;

    logic [DW-1:0] dbcnt;
    logic          level;
    logic          last_level;

    sync2 #(.W(4)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (col_raw),
        .q    (col_s)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= BLANK;
        end else begin
            state <= state_n;
        end
    end

    // Hold check wins over rotation so a key seen on the last scan cycle
    // keeps its row.
    always_comb begin
        state_n = state;
        rotate  = 1'b0;
        cnt_inc = 1'b0;
        unique case (state)
            BLANK: begin
                cnt_inc = 1'b1;
                if (cnt == BLANK_LAST) begin
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (col_s != 4'd0 || dbreq) begin
                    state_n = HOLD;
                end else if (cnt == CNT_LAST) begin
                    rotate  = 1'b1;
                    state_n = BLANK;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (!dbreq && col_s == 4'd0) begin
                    rotate  = 1'b1;
                    state_n = BLANK;
                end
            end
            default: begin
                state_n = BLANK;
            end
        endcase
    end

    always_comb begin
        col = col_s;
        if (state == BLANK) begin
            col = 4'd0;
        end
        row = row_drive;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_drive <= ROW_INIT;
            cnt       <= '0;
        end else if (rotate) begin
            row_drive <= {row_drive[2:0], row_drive[3]};
            cnt       <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = |(col_s & active_col);

    // The verdict sample also opens the next window, so verdicts
    // repeat every DB_CYCLES while the level holds.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dbcnt      <= '0;
            last_level <= 1'b0;
            dbhigh     <= 1'b0;
            dblow      <= 1'b0;
        end else begin
            last_level <= level;
            dbhigh     <= 1'b0;
            dblow      <= 1'b0;
            if (!dbreq) begin
                dbcnt <= '0;
            end else if (dbcnt == DB_LAST) begin
                dbcnt  <= DW'(1);
                dbhigh <= last_level;
                dblow  <= !last_level;
            end else if (level != last_level) begin
                dbcnt <= DW'(1);
            end else begin
                dbcnt <= dbcnt + 1'b1;
            end
        end
    end

`ifdef KEYSCAN_DEBUG_EN
    logic row_onehot_err;
    logic row_bad;

    assign debug_state = state;
    assign row_bad = (row_drive == 4'd0) ||
                     ((row_drive & (row_drive - 4'd1)) != 4'd0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_onehot_err <= 1'b0;
        end else if (row_bad) begin
            row_onehot_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized scoreboard bench for keypad_scan_ctrl with a keypad matrix
// model driving col_raw from row_drive.
module tb_keypad_scan_ctrl;

    localparam int SD = 8;
    localparam int DB = 5;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] col_raw;
    logic [3:0] row_drive;
    logic [3:0] col;
    logic [3:0] row;
    logic       dbreq;
    logic [3:0] active_col;
    logic       dbhigh;
    logic       dblow;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV  (SD),
        .DB_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .col_raw    (col_raw),
        .row_drive  (row_drive),
        .col        (col),
        .row        (row),
        .dbreq      (dbreq),
        .active_col (active_col),
        .dbhigh     (dbhigh),
        .dblow      (dblow)
    );

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic       hi;
        logic       lo;
    } exp_t;

    typedef struct {
        bit req;
        bit lvl;
    } smp_t;

    exp_t       exp_q[$];
    smp_t       win[$];
    logic [3:0] keymat[4];
    int         errors = 0;
    int         checks = 0;

    // Reference: a row position with a phase count inside it, plus a
    // sliding window of the last DB debounce samples.
    logic [3:0] m_s1, m_s2;
    int         m_row, m_ph, since;
    bit         m_hold;

    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] cs;
        bit         lv, hi, lo, ok;
        hi = 1'b0;
        lo = 1'b0;
        if (!rstn) begin
            m_s1 = 4'd0;
            m_s2 = 4'd0;
            m_row = 0;
            m_ph = 0;
            m_hold = 1'b0;
            win.delete();
            since = DB;
        end else begin
            cs = m_s2;
            lv = |(cs & active_col);
            if (dbreq && win.size() == DB && since >= DB) begin
                ok = 1'b1;
                foreach (win[i])
                    if (!win[i].req || win[i].lvl != win[0].lvl) ok = 1'b0;
                if (ok) begin
                    hi = win[0].lvl;
                    lo = !win[0].lvl;
                    since = 0;
                end
            end
            win.push_back('{dbreq, lv});
            if (win.size() > DB) void'(win.pop_front());
            since++;
            if (m_hold) begin
                if (!dbreq && cs == 4'd0) begin
                    m_row = (m_row + 1) % 4;
                    m_ph = 0;
                    m_hold = 1'b0;
                end
            end else if (m_ph < 3) begin
                m_ph++;
            end else if (cs != 4'd0 || dbreq) begin
                m_hold = 1'b1;
            end else if (m_ph == SD - 1) begin
                m_row = (m_row + 1) % 4;
                m_ph = 0;
            end else begin
                m_ph++;
            end
            m_s2 = m_s1;
            m_s1 = col_raw;
        end
        e.row = 4'b0001 << m_row;
        e.col = (!m_hold && m_ph < 3) ? 4'd0 : m_s2;
        e.hi = hi;
        e.lo = lo;
        exp_q.push_back(e);
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (row_drive !== e.row || row !== e.row || col !== e.col ||
                    dbhigh !== e.hi || dblow !== e.lo) begin
                    errors++;
                    $display("FAIL scb t=%0t got row_drive=%b row=%b col=%b hi=%b lo=%b want row=%b col=%b hi=%b lo=%b",
                             $time, row_drive, row, col, dbhigh, dblow,
                             e.row, e.col, e.hi, e.lo);
                end
            end
        end
    end

    function automatic logic [3:0] kp(input logic [3:0] r);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 0; i < 4; i++)
            if (r[i]) v = v | keymat[i];
        return v;
    endfunction

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            col_raw = kp(row_drive);
        end
    endtask

    task automatic wait_col(input string nm, input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            cyc();
            if (col != 4'd0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: col=%b after %0d cycles, required nonzero", nm, col, lim);
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", nm, act, req);
        end
    endtask

    task automatic clear_keys();
        for (int i = 0; i < 4; i++) keymat[i] = 4'd0;
    endtask

    initial begin
        logic [3:0] c;
        rstn = 1'b0;
        col_raw = 4'd0;
        dbreq = 1'b0;
        active_col = 4'd0;
        clear_keys();
        cyc(3);
        rstn = 1'b1;
        cyc(40);

        keymat[1] = 4'b0100;
        wait_col("detect_row1", 64);
        chk("hold_row1", row_drive, 4'b0010);
        chk("hold_col1", col, 4'b0100);
        dbreq = 1'b1;
        active_col = 4'b0100;
        cyc(20);
        for (int k = 0; k < 6; k++) begin
            keymat[1] = keymat[1] ^ 4'b0100;
            cyc(2);
        end
        chk("frozen_row1", row_drive, 4'b0010);
        keymat[1] = 4'd0;
        cyc(15);
        dbreq = 1'b0;
        active_col = 4'd0;
        cyc(20);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0)
                keymat[$urandom_range(0, 3)][$urandom_range(0, 3)] ^= 1'b1;
            if (!dbreq && col != 4'd0) begin
                c = col;
                dbreq = 1'b1;
                active_col = c & (~c + 4'd1);
            end else if (!dbreq && $urandom_range(0, 49) == 0) begin
                dbreq = 1'b1;
                active_col = 4'b0001 << $urandom_range(0, 3);
            end else if (dbreq && $urandom_range(0, 19) == 0) begin
                dbreq = 1'b0;
                active_col = 4'd0;
            end
            cyc();
        end

        clear_keys();
        dbreq = 1'b0;
        active_col = 4'd0;
        cyc(40);
        keymat[3] = 4'b0010;
        wait_col("detect_row3", 64);
        chk("hold_row3", row_drive, 4'b1000);
        dbreq = 1'b1;
        active_col = 4'b0010;
        cyc(3);
        rstn = 1'b0;
        clear_keys();
        cyc();
        rstn = 1'b1;
        dbreq = 1'b0;
        active_col = 4'd0;
        chk("reset_row", row_drive, 4'b0001);
        cyc(30);

        cyc(2);
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL scb_drain got %0d pending required at most 1", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
